// File: rtl/sprite_line_ctrl.sv
// Sprite scanline controller: fetches the next bitmap row during horizontal blanking
// and shifts it out one pixel per clock at the sprite's X position.
module sprite_line_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic             pos_we,
  output logic [3:0]       rom_addr,
  input  logic [SPR_W-1:0] rom_data,
  output logic             sprite_pix,
  output logic             sprite_hit
);

  localparam int CW = $clog2(SPR_W);
  localparam logic [9:0] H_END    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_END    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] SPR_ROWS = 10'(SPR_H);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPR_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] WAIT_X = 3'd3;
  localparam logic [2:0] SHIFT  = 3'd4;

  logic [2:0]       state;
  logic [9:0]       pend_x, pend_y, act_x, act_y;
  logic [9:0]       nv, r;
  logic             spr_line, frame_start;
  logic [SPR_W-1:0] line_buf, shifter;
  logic             line_buf_valid;
  logic [CW-1:0]    cnt;

  // Row offset wraps mod 1024, so a sprite near the bottom never leaks into line 0.
  always_comb begin
    nv          = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    r           = nv - act_y;
    spr_line    = (r < SPR_ROWS) && (nv < V_END);
    frame_start = (hcount == 10'd0) && (vcount == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_x <= '0;
      pend_y <= '0;
      act_x  <= '0;
      act_y  <= '0;
    end else begin
      if (pos_we) begin
        pend_x <= pos_x;
        pend_y <= pos_y;
      end
      if (frame_start) begin
        act_x <= pend_x;
        act_y <= pend_y;
      end
    end
  end

  // The first pixel is emitted straight from line_buf so column h appears one cycle after hcount==h.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rom_addr       <= '0;
      line_buf       <= '0;
      line_buf_valid <= 1'b0;
      shifter        <= '0;
      cnt            <= '0;
      sprite_hit     <= 1'b0;
      sprite_pix     <= 1'b0;
    end else begin
      sprite_hit <= 1'b0;
      sprite_pix <= 1'b0;
      case (state)
        IDLE: begin
          if (hcount == H_END) begin
            if (spr_line) state <= FETCH;
            else          line_buf_valid <= 1'b0;
          end
        end
        FETCH: begin
          rom_addr <= r[3:0];
          state    <= LATCH;
        end
        LATCH: begin
          line_buf       <= rom_data;
          line_buf_valid <= 1'b1;
          state          <= WAIT_X;
        end
        WAIT_X: begin
          if (hcount == H_END) begin
            if (spr_line) begin
              state <= FETCH;
            end else begin
              line_buf_valid <= 1'b0;
              state          <= IDLE;
            end
          end else if (hcount < H_END && hcount == act_x && line_buf_valid) begin
            sprite_hit <= 1'b1;
            sprite_pix <= line_buf[0];
            shifter    <= line_buf >> 1;
            cnt        <= CW'(1);
            state      <= (hcount == H_LAST) ? IDLE : SHIFT;
          end
        end
        SHIFT: begin
          sprite_hit <= 1'b1;
          sprite_pix <= shifter[0];
          shifter    <= shifter >> 1;
          cnt        <= cnt + CW'(1);
          if (cnt == CNT_LAST || hcount == H_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
